// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory Wishbone arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RD_WAIT = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_MASTERS = 2;
    localparam int DEF_AW          = 32;
    localparam int DEF_DW          = 32;

    // Width of a master index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter
    import dmem_arb_pkg::*;
#(
    parameter  int N  = DEF_NUM_MASTERS,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          vld
);

    int k;

    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        k   = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr) + i;
            if (k >= N) k = k - N;
            if (!vld && req[k]) begin
                vld    = 1'b1;
                gnt[k] = 1'b1;
                idx    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/dmem_wb_arbiter.sv
// Round-robin Wishbone arbiter in front of the single-port data memory.
// Optional bus locking for atomics is enabled with `define DMEM_ARB_LOCK_EN.
module dmem_wb_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
`ifdef DMEM_ARB_LOCK_EN
    input  logic [NUM_MASTERS-1:0]      m_lock_i,
`endif
    output logic [NUM_MASTERS*DW-1:0]   m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW/8-1:0]             s_sel_o,
    output logic [DW-1:0]               s_dat_o,
    input  logic [DW-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    output logic [NUM_MASTERS-1:0]      gnt_o
);

    localparam int IW = idx_w(NUM_MASTERS);
    localparam int SW = DW / 8;

    arb_state_e             state;
    logic [IW-1:0]          g;
    logic [IW-1:0]          ptr;
    logic [NUM_MASTERS-1:0] gnt_q;
    logic [IW-1:0]          nxt_ptr;

    logic [NUM_MASTERS-1:0] lock_v;
    logic [NUM_MASTERS-1:0] rr_gnt;
    logic [IW-1:0]          rr_idx;
    logic                   rr_vld;

    logic [AW-1:0] adr_a [NUM_MASTERS];
    logic [SW-1:0] sel_a [NUM_MASTERS];
    logic [DW-1:0] dat_a [NUM_MASTERS];

`ifdef DMEM_ARB_LOCK_EN
    assign lock_v = m_lock_i;
`else
    assign lock_v = '0;
`endif

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
        assign adr_a[k] = m_adr_i[k*AW +: AW];
        assign sel_a[k] = m_sel_i[k*SW +: SW];
        assign dat_a[k] = m_dat_i[k*DW +: DW];
    end

    rr_arbiter #(.N(NUM_MASTERS)) u_rr (
        .req (m_cyc_i & m_stb_i),
        .ptr (ptr),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .vld (rr_vld)
    );

    logic cur_cyc, cur_stb, cur_we, cur_lock, busy_act, rd_wait;

    assign cur_cyc  = m_cyc_i[g];
    assign cur_stb  = m_stb_i[g];
    assign cur_we   = m_we_i[g];
    assign cur_lock = lock_v[g];
    assign busy_act = (state == BUSY) && cur_cyc;
    assign rd_wait  = (state == RD_WAIT);
    assign nxt_ptr  = (g == IW'(NUM_MASTERS - 1)) ? '0 : g + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            g     <= '0;
            gnt_q <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rr_vld) begin
                        g     <= rr_idx;
                        gnt_q <= rr_gnt;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!cur_cyc) begin
                        // A locked master keeps the bus across its own cycle gaps.
                        if (!cur_lock) begin
                            state <= IDLE;
                            gnt_q <= '0;
                            ptr   <= nxt_ptr;
                        end
                    end else if (cur_stb && !cur_we && s_ack_i) begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (cur_cyc || cur_lock) begin
                        state <= BUSY;
                    end else begin
                        state <= IDLE;
                        gnt_q <= '0;
                        ptr   <= nxt_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Slave side: strobe only in BUSY so a read is never issued twice.
    assign s_cyc_o = busy_act || rd_wait;
    assign s_stb_o = busy_act && cur_stb;
    assign s_we_o  = busy_act && cur_we;
    assign s_adr_o = busy_act ? adr_a[g] : '0;
    assign s_sel_o = busy_act ? sel_a[g] : '0;
    assign s_dat_o = busy_act ? dat_a[g] : '0;

    // Writes ack with the slave; reads ack one cycle later with the registered data.
    logic ack_any;
    assign ack_any = (busy_act && cur_stb && cur_we && s_ack_i) || (rd_wait && cur_cyc);
    assign m_ack_o = ack_any ? gnt_q : '0;
    assign gnt_o   = gnt_q;

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_rdata
        assign m_dat_o[k*DW +: DW] = (rst_ni && rd_wait && cur_cyc && gnt_q[k]) ? s_dat_i : '0;
    end

endmodule

// File: tb/tb_dmem_wb_arbiter.sv
// Scoreboard bench for dmem_wb_arbiter with a behavioural single-port memory slave.
module tb_dmem_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  m_cyc = '0, m_stb = '0, m_we = '0;
    logic [63:0] m_adr = '0, m_wdat = '0;
    logic [7:0]  m_sel = '0;
    logic [63:0] m_rdat;
    logic [1:0]  m_ack, gnt;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic [3:0]  s_sel;
`ifdef DMEM_ARB_LOCK_EN
    logic [1:0]  m_lock = '0;
`endif

    always #5 clk = ~clk;

    dmem_wb_arbiter #(.NUM_MASTERS(2), .AW(32), .DW(32)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_we_i  (m_we),
        .m_adr_i (m_adr),
        .m_sel_i (m_sel),
        .m_dat_i (m_wdat),
`ifdef DMEM_ARB_LOCK_EN
        .m_lock_i(m_lock),
`endif
        .m_dat_o (m_rdat),
        .m_ack_o (m_ack),
        .s_cyc_o (s_cyc),
        .s_stb_o (s_stb),
        .s_we_o  (s_we),
        .s_adr_o (s_adr),
        .s_sel_o (s_sel),
        .s_dat_o (s_wdat),
        .s_dat_i (s_rdat),
        .s_ack_i (s_ack),
        .gnt_o   (gnt)
    );

    // Slave: combinational ack, write at the ack edge, read data registered.
    logic [31:0] mem [64];
    int          wr_cnt = 0;
    assign s_ack = s_stb;
    always @(posedge clk) begin
        if (s_stb && s_ack) begin
            if (s_we) begin
                for (int b = 0; b < 4; b++)
                    if (s_sel[b]) mem[s_adr[7:2]][b*8 +: 8] <= s_wdat[b*8 +: 8];
                wr_cnt <= wr_cnt + 1;
            end else begin
                s_rdat <= mem[s_adr[7:2]];
            end
        end
    end

    typedef struct {
        int          mst;
        bit          rd;
        logic [31:0] dat;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int mst, input bit rd, input logic [31:0] dat);
        exp_t e;
        e.mst = mst; e.rd = rd; e.dat = dat;
        sb.push_back(e);
    endtask

    // Monitor: every ack must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && m_ack != 2'b00) begin
            chk("ack_to_granted", 64'(m_ack & ~gnt), 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", 64'(m_ack), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_master", 64'(m_ack), 64'(2'b01 << e.mst));
                if (e.rd) chk("rd_data", 64'(m_rdat[e.mst*32 +: 32]), 64'(e.dat));
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_m(input int k, input bit c, input bit w, input logic [31:0] a, input logic [31:0] d);
        m_cyc[k] = c;
        m_stb[k] = c;
        m_we[k]  = w;
        m_adr[k*32 +: 32] = a;
        m_wdat[k*32 +: 32] = d;
        m_sel[k*4 +: 4] = c ? 4'hF : 4'h0;
    endtask

    task automatic clr_m(input int k);
        set_m(k, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_scyc_sstb", {62'd0, s_cyc, s_stb}, 64'd0);
        chk("rst_ack", 64'(m_ack), 64'd0);
        chk("rst_mdat", m_rdat, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    int base;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Single write by master 0: bubble, then ack with strobe.
        push(0, 1'b0, 32'h0);
        set_m(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        smp(); chk("wr_bubble_stb", 64'(s_stb), 64'd0); chk("wr_bubble_ack", 64'(m_ack), 64'd0);
        smp(); chk("wr_stb", 64'(s_stb), 64'd1); chk("wr_ack", 64'(m_ack), 64'd1);
        chk("wr_adr", 64'(s_adr), 64'h10); chk("wr_gnt", 64'(gnt), 64'd1);
        tick(); clr_m(0);
        smp(); chk("wr_release_cyc", 64'(s_cyc), 64'd0);
        tick(); chk("wr_once", 64'(wr_cnt), 64'd1);

        // Read back by master 0: ack two cycles after request.
        push(0, 1'b1, 32'hDEADBEEF);
        set_m(0, 1'b1, 1'b0, 32'h10, 32'h0);
        smp(); chk("rd_bubble_ack", 64'(m_ack), 64'd0);
        smp(); chk("rd_stb", 64'(s_stb), 64'd1); chk("rd_early_ack", 64'(m_ack), 64'd0);
        smp(); chk("rd_ack", 64'(m_ack), 64'd1); chk("rd_stb_low", 64'(s_stb), 64'd0);
        chk("rd_lanes", m_rdat, 64'h0000_0000_DEAD_BEEF);
        tick(); clr_m(0);
        smp(); tick();

        // Simultaneous writes after reset: 0 then 1, then 0 again.
        do_reset();
        push(0, 1'b0, 32'h0); push(1, 1'b0, 32'h0);
        set_m(0, 1'b1, 1'b1, 32'h20, 32'h1111_1111);
        set_m(1, 1'b1, 1'b1, 32'h24, 32'h2222_2222);
        smp(); chk("sim_bubble_gnt", 64'(gnt), 64'd0);
        smp(); chk("sim_gnt0", 64'(gnt), 64'd1);
        tick(); clr_m(0);
        smp(); chk("sim_no_preempt_ack", 64'(m_ack), 64'd0); chk("sim_hold_gnt0", 64'(gnt), 64'd1);
        smp(); chk("sim_idle_gap", 64'(gnt), 64'd0);
        smp(); chk("sim_gnt1", 64'(gnt), 64'd2); chk("sim_ack1", 64'(m_ack), 64'd2);
        tick(); clr_m(1);
        smp(); tick();
        push(0, 1'b0, 32'h0);
        set_m(0, 1'b1, 1'b1, 32'h28, 32'h3333_3333);
        set_m(1, 1'b1, 1'b1, 32'h2C, 32'h4444_4444);
        smp(); smp(); chk("alt_gnt0", 64'(gnt), 64'd1);
        tick(); clr_m(0); clr_m(1);
        smp(); tick();
        chk("mem_20", 64'(mem[8]), 64'h1111_1111);
        chk("mem_24", 64'(mem[9]), 64'h2222_2222);

        // Master 1 read abandoned in RD_WAIT: no ack, pointer returns to 0.
        set_m(1, 1'b1, 1'b0, 32'h24, 32'h0);
        smp(); smp(); chk("ab_gnt1", 64'(gnt), 64'd2); chk("ab_stb", 64'(s_stb), 64'd1);
        tick(); clr_m(1);
        smp(); chk("ab_no_ack", 64'(m_ack), 64'd0); chk("ab_no_data", m_rdat, 64'd0);
        chk("ab_scyc", 64'(s_cyc), 64'd1);
        smp(); chk("ab_idle", 64'(gnt), 64'd0);
        tick();
        push(0, 1'b0, 32'h0);
        set_m(0, 1'b1, 1'b1, 32'h28, 32'h5555_5555);
        set_m(1, 1'b1, 1'b1, 32'h2C, 32'h6666_6666);
        smp(); smp(); chk("ab_ptr0", 64'(gnt), 64'd1);
        tick(); clr_m(0); clr_m(1);
        smp(); tick();

        // Back-to-back writes by master 0 holding cyc.
        base = wr_cnt;
        push(0, 1'b0, 32'h0); push(0, 1'b0, 32'h0);
        set_m(0, 1'b1, 1'b1, 32'h30, 32'hAAAA_0001);
        smp(); smp(); chk("b2b_ack1", 64'(m_ack), 64'd1);
        tick(); set_m(0, 1'b1, 1'b1, 32'h34, 32'hAAAA_0002);
        smp(); chk("b2b_ack2", 64'(m_ack), 64'd1); chk("b2b_adr2", 64'(s_adr), 64'h34);
        tick(); clr_m(0);
        smp(); tick();
        chk("b2b_count", 64'(wr_cnt - base), 64'd2);
        chk("b2b_mem", 64'(mem[13]), 64'hAAAA_0002);

        // Reset asserted mid write: everything drops at once, write aborted.
        base = wr_cnt;
        push(0, 1'b0, 32'h0);
        set_m(0, 1'b1, 1'b1, 32'h38, 32'hBBBB_BBBB);
        smp(); smp(); chk("rst_mid_ack_before", 64'(m_ack), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_bus", {60'd0, s_cyc, s_stb, gnt}, 64'd0);
        chk("rst_mid_ack", 64'(m_ack), 64'd0);
        clr_m(0);
        @(negedge clk); rst_n = 1'b1;
        smp(); chk("rst_mid_idle", {61'd0, s_cyc, gnt}, 64'd0);
        chk("rst_mid_no_write", 64'(wr_cnt - base), 64'd0);
        tick();

`ifdef DMEM_ARB_LOCK_EN
        // Locked master 0 keeps the grant across a cyc gap while master 1 waits.
        push(0, 1'b0, 32'h0); push(0, 1'b0, 32'h0); push(1, 1'b0, 32'h0);
        m_lock[0] = 1'b1;
        set_m(0, 1'b1, 1'b1, 32'h40, 32'hC0C0_C0C0);
        set_m(1, 1'b1, 1'b1, 32'h44, 32'hD1D1_D1D1);
        smp(); smp(); chk("lk_ack0", 64'(m_ack), 64'd1);
        tick(); clr_m(0);
        smp(); chk("lk_hold_a", 64'(gnt), 64'd1); chk("lk_gap_cyc", 64'(s_cyc), 64'd0);
        smp(); chk("lk_hold_b", 64'(gnt), 64'd1);
        tick(); set_m(0, 1'b1, 1'b1, 32'h48, 32'hC1C1_C1C1);
        smp(); chk("lk_ack0_again", 64'(m_ack), 64'd1);
        tick(); clr_m(0); m_lock[0] = 1'b0;
        smp(); chk("lk_release_gnt", 64'(gnt), 64'd1);
        smp(); chk("lk_idle", 64'(gnt), 64'd0);
        smp(); chk("lk_gnt1", 64'(gnt), 64'd2);
        tick(); clr_m(1);
        smp(); tick();
`endif

        repeat (3) tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_wb_arbiter.md
Name: dmem_wb_arbiter

Overview:
Round-robin Wishbone arbiter sharing the single-port data memory slave between NUM_MASTERS requesters (core LSU, debug/DMA port).
- Sits between the masters and the data memory slave.
- The slave acks combinationally in the strobe cycle but returns read data registered one cycle later.
- For reads, the arbiter realigns the master-side ack with that data; masters see standard Wishbone behaviour.

Parameters:
NUM_MASTERS, 2, number of requesting masters (>=2)
AW, 32, address width
DW, 32, data width (byte lanes = DW/8)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
m_cyc_i  in  NUM_MASTERS  per-master cycle
m_stb_i  in  NUM_MASTERS  per-master strobe
m_we_i  in  NUM_MASTERS  per-master write enable
m_adr_i  in  NUM_MASTERS*AW  packed addresses, master k at [k*AW +: AW]
m_sel_i  in  NUM_MASTERS*DW/8  packed byte selects
m_dat_i  in  NUM_MASTERS*DW  packed write data
m_dat_o  out  NUM_MASTERS*DW  read data per master
m_ack_o  out  NUM_MASTERS  per-master ack
s_cyc_o  out  1  slave cycle
s_stb_o  out  1  slave strobe
s_we_o  out  1  slave write enable
s_adr_o  out  AW  slave address
s_sel_o  out  DW/8  slave byte select
s_dat_o  out  DW  slave write data
s_dat_i  in  DW  slave read data (valid the cycle after its ack)
s_ack_i  in  1  slave ack (same cycle as strobe)
gnt_o  out  NUM_MASTERS  one-hot current grant (debug)

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE, grant=0, rr pointer=0.
  - All outputs 0 immediately, including m_ack_o, gnt_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o.
  - m_dat_o forced 0 while in reset.
- States: IDLE, BUSY, RD_WAIT; grant index g is registered.
- IDLE:
  - Request vector = m_cyc_i & m_stb_i.
  - If nonzero: choose the first requester at or after the rr pointer, wrapping modulo NUM_MASTERS.
  - Register g and go to BUSY.
  - No slave access occurs in IDLE; the 1-cycle arbitration bubble is required.
- BUSY:
  - s_cyc_o=1; s_stb_o/we/adr/sel/dat_o are muxed combinationally from master g. gnt_o is one-hot g.
  - Write with s_ack_i: m_ack_o[g]=1 in the same cycle. Stay in BUSY.
  - Read with s_ack_i: m_ack_o stays 0. Go to RD_WAIT.
  - If m_cyc_i[g]=0: go to IDLE, rr pointer=(g+1) mod NUM_MASTERS, s_cyc_o=0 in that cycle.
- RD_WAIT:
  - s_cyc_o=1 and s_stb_o=0, so the slave does not access memory twice.
  - m_ack_o[g]=1 and m_dat_o[g]=s_dat_i.
  - Next state: BUSY if m_cyc_i[g]=1, else IDLE (pointer advances as above).
  - If m_cyc_i[g] dropped during RD_WAIT: ack suppressed, data discarded, go to IDLE.
- Latency from request in IDLE:
  - Write: ack 1 cycle later.
  - Read: ack with data 2 cycles later.
  - Back-to-back beats by the same master while holding cyc: write 1/cycle, read 1 per 2 cycles.
- Master-side rules:
  - m_dat_o lanes of non-granted masters are 0.
  - m_ack_o is never asserted to a non-granted master.
  - Requests from non-granted masters are ignored until the grant is released. There is no preemption.
- Simultaneous release and new requests:
  - Release costs one IDLE cycle before the next grant; the new grant uses the updated pointer.
- Any rst_ni assertion mid-transfer aborts it; no ack is issued.

Optional Feature:
DMEM_ARB_LOCK_EN
- With the macro: adds input m_lock_i [NUM_MASTERS].
  - If m_lock_i[g]=1 when m_cyc_i[g] drops, the grant is retained and state goes to BUSY with the pointer unchanged.
  - This lets read-modify-write sequences (atomics) hold the bus across cycle boundaries.
  - The grant is released only when cyc and lock are both low.
- Without the macro: no m_lock_i port; release is purely on cyc.

Decomposition:
- Package dmem_arb_pkg:
  - arb_state_e enum (IDLE, BUSY, RD_WAIT).
  - Default NUM_MASTERS, AW, DW localparams.
  - Grant index width function.
- Sub-module rr_arbiter: parameterised combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, valid.
- FSM and muxing stay in dmem_wb_arbiter.

Test Plan:
- Master0 writes adr 0x10, dat 0xDEADBEEF, sel 0xF -> s_stb_o=1 and m_ack_o[0]=1 exactly 1 cycle after request; slave sees the write once.
- Master0 reads 0x10 -> s_stb_o pulses 1 cycle, then m_ack_o[0]=1 with m_dat_o[0]=0xDEADBEEF 2 cycles after request; m_ack_o[1]=0 throughout.
- Both masters request single writes in the same cycle after reset -> master0 served first; master1 granted 1 IDLE cycle after master0 drops cyc; a repeated simultaneous request then grants master0 again (alternation).
- Master1 read granted, drops cyc in RD_WAIT -> no m_ack_o[1], state IDLE next cycle, pointer=0.
- rst_ni pulled low in BUSY during a write -> s_cyc_o, s_stb_o, m_ack_o and gnt_o all 0 in the same cycle; after release, state is IDLE.
- With DMEM_ARB_LOCK_EN: master0 holds m_lock_i=1 and drops/reasserts cyc while master1 requests -> master0 keeps the grant; master1 is granted only after master0 lock=0 and cyc=0.
